// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM-state types for the sequential stack-machine ALU.
package alu_seq_pkg;

   typedef enum logic [3:0] {
      OP_ILL  = 4'd0,
      OP_ADD  = 4'd1,
      OP_SUB  = 4'd2,
      OP_MUL  = 4'd3,
      OP_DIV  = 4'd4,
      OP_MOD  = 4'd5,
      OP_AND  = 4'd6,
      OP_OR   = 4'd7,
      OP_XOR  = 4'd8,
      OP_NOT  = 4'd9,
      OP_PASS = 4'd10,
      OP_SHL  = 4'd11,
      OP_SHR  = 4'd12,
      OP_LT   = 4'd13,
      OP_GE   = 4'd14,
      OP_EQ   = 4'd15
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_FIX  = 2'd2
   } state_e;

   function automatic logic is_div_op(input op_e op);
      return (op == OP_DIV) || (op == OP_MOD);
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response handshake bundle between the stack control FSM and alu_seq.
interface alu_seq_if #(parameter int W = 16);

   logic         in_valid;
   logic         in_ready;
   logic [3:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] res;
   logic         err;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, res, err
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, res, err
   );

endinterface

// File: rtl/alu_seq_div_iter.sv
// Unsigned W-bit restoring divider, one quotient bit per clock after start.
// Only instantiated when ALU_DIV_EN is defined.
module alu_div_iter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] quot,
   output logic [W-1:0] rem
);

   localparam int CW = $clog2(W + 1);

   logic [W-1:0]  rem_q, rem_d;
   logic [W-1:0]  quot_q, quot_d;
   logic [W-1:0]  dvsr_q;
   logic [CW-1:0] cnt_q;
   logic          busy_q;
   logic [W+1:0]  trial;

   // Partial remainder stays below 2*divisor, so W+2 bits hold the signed trial difference.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      rem_d  = rem_q;
      quot_d = quot_q;
      trial  = {1'b0, rem_q, quot_q[W-1]} - {2'b00, dvsr_q};
      if (trial[W+1]) rem_d = {rem_q[W-2:0], quot_q[W-1]};
      else            rem_d = trial[W-1:0];
      quot_d = {quot_q[W-2:0], ~trial[W+1]};
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_q  <= '0;
         quot_q <= '0;
         dvsr_q <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else if (start) begin
         rem_q  <= '0;
         quot_q <= dividend;
         dvsr_q <= divisor;
         cnt_q  <= CW'(W);
         busy_q <= 1'b1;
      end else if (busy_q) begin
         rem_q  <= rem_d;
         quot_q <= quot_d;
         cnt_q  <= cnt_q - CW'(1);
         busy_q <= (cnt_q != CW'(1));
      end
   end

   // done marks the cycle whose closing edge performs the final iteration.
   assign done = busy_q & (cnt_q == CW'(1));
   assign busy = busy_q;
   assign quot = quot_q;
   assign rem  = rem_q;

endmodule

// File: rtl/alu_seq.sv
// Handshaked W-bit stack ALU: registered single-cycle ops plus iterative signed DIV/MOD.
// Define ALU_DIV_EN to build the divider; without it DIV/MOD return err=1 in one cycle.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int W = 16
) (
   input logic     clk,
   input logic     rst,
   alu_seq_if.slave bus
);

   localparam int           SHW    = $clog2(W);
   localparam logic [W-1:0] W_WORD = W'(W);

   typedef struct packed {
      logic         err;
      logic [W-1:0] res;
   } result_t;

   state_e       state_q, state_d;
   logic         out_valid_q, out_valid_d;
   logic         err_q, err_d;
   logic [W-1:0] res_q, res_d;
   logic         in_ready, accept, drain;
   logic         div_go, div_done;
   logic [W-1:0] fix_res;
   op_e          op;
   result_t      single;

   assign op = op_e'(bus.op);

   function automatic result_t calc(input op_e f, input logic [W-1:0] a, input logic [W-1:0] b);
      result_t r;
      r = '0;
      case (f)
         OP_ADD:  r.res = a + b;
         OP_SUB:  r.res = a - b;
         OP_MUL:  r.res = a * b;
`ifdef ALU_DIV_EN
         // Only the zero-divisor case completes here; non-zero divisors take the iterative path.
         OP_DIV:  begin r.res = '1; r.err = 1'b1; end
         OP_MOD:  begin r.res = a;  r.err = 1'b1; end
`else
         OP_DIV:  r.err = 1'b1;
         OP_MOD:  r.err = 1'b1;
`endif
         OP_AND:  r.res = a & b;
         OP_OR:   r.res = a | b;
         OP_XOR:  r.res = a ^ b;
         OP_NOT:  r.res = ~b;
         OP_PASS: r.res = b;
         OP_SHL:  r.res = (b >= W_WORD) ? '0 : a << b[SHW-1:0];
         OP_SHR:  r.res = (b >= W_WORD) ? '0 : a >> b[SHW-1:0];
         OP_LT:   r.res = {W{$signed(a) <  $signed(b)}};
         OP_GE:   r.res = {W{$signed(a) >= $signed(b)}};
         OP_EQ:   r.res = {W{a == b}};
         default: r.err = 1'b1;
      endcase
      return r;
   endfunction

   assign single = calc(op, bus.a, bus.b);

`ifdef ALU_DIV_EN
   logic         div_start;
   logic         quot_neg_q, rem_neg_q, mod_q;
   logic         div_busy;
   logic [W-1:0] quot, rem;

   assign div_go    = is_div_op(op) && (bus.b != '0);
   assign div_start = accept & div_go;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         quot_neg_q <= 1'b0;
         rem_neg_q  <= 1'b0;
         mod_q      <= 1'b0;
      end else if (div_start) begin
         quot_neg_q <= bus.a[W-1] ^ bus.b[W-1];
         rem_neg_q  <= bus.a[W-1];
         mod_q      <= (op == OP_MOD);
      end
   end

   // MIN has no positive twin, but its negation is the same bit pattern read as unsigned.
   alu_div_iter #(.W(W)) u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start),
      .dividend (bus.a[W-1] ? -bus.a : bus.a),
      .divisor  (bus.b[W-1] ? -bus.b : bus.b),
      .busy     (div_busy),
      .done     (div_done),
      .quot     (quot),
      .rem      (rem)
   );

   assign fix_res = mod_q ? (rem_neg_q  ? -rem  : rem)
                          : (quot_neg_q ? -quot : quot);
`else
   assign div_go   = 1'b0;
   assign div_done = 1'b0;
   assign fix_res  = '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept && div_go) state_d = ST_DIV;
         ST_DIV:  if (div_done)         state_d = ST_FIX;
         ST_FIX:                        state_d = ST_IDLE;
         default:                       state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state_q == ST_IDLE) & (~out_valid_q | bus.out_ready);
      accept   = bus.in_valid & in_ready;
      drain    = out_valid_q & bus.out_ready;
   end

   // A new load on the drain edge keeps out_valid high for full-rate streaming.
   always_comb begin
      res_d       = res_q;
      err_d       = err_q;
      out_valid_d = out_valid_q & ~drain;
      if (accept && !div_go) begin
         res_d       = single.res;
         err_d       = single.err;
         out_valid_d = 1'b1;
      end else if (state_q == ST_FIX) begin
         res_d       = fix_res;
         err_d       = 1'b0;
         out_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_q       <= '0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         res_q       <= res_d;
         err_q       <= err_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.res       = res_q;
   assign bus.err       = err_q;

endmodule
